pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Supervises the board PLL (25 MHz in; 50/25/100 MHz out) from the 25 MHz reference clock.
- Pulses the PLL reset and waits for a stable lock, with timeout and bounded retries.
- Then releases per-domain resets one at a time, in index order.
- Downstream clock domains re-synchronize their own domain_rst_n bit; this block only sequences.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release (>=1)
LOCK_TIMEOUT_CYCLES, 65536, cycles allowed from WAIT_LOCK entry to reaching RELEASE (> LOCK_STABLE_CYCLES)
STAGE_GAP_CYCLES, 8, cycles between successive domain reset releases (>=1)
NUM_DOMAINS, 3, number of domain reset outputs (1..8)
MAX_RETRIES, 7, failed attempts tolerated before FAULT (1..15)

Ports:
clock  in  1  25 MHz reference clock, same source as PLL input
reset_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL LOCK, asynchronous to clock
soft_rst  in  1  synchronous restart request, single-cycle pulse
pll_rst  out  1  PLL RST, registered, active high
domain_rst_n  out  NUM_DOMAINS  per-domain resets, active low, registered
ready  out  1  high in RUN only
lock_lost  out  1  one-cycle pulse on lock loss after release began
fault  out  1  high in FAULT
retry_count  out  4  failed attempts since reset/soft_rst, saturating at 15

Behaviour:
- Reset (reset_n low, async): state=PLL_RESET, pll_rst=1, domain_rst_n=all 0, ready=0, lock_lost=0, fault=0, retry_count=0, all counters 0, synchronizer flops 0.
- pll_locked passes through a 2-flop synchronizer (locked_s); a 2-cycle latency applies to every lock-based decision.
- PLL_RESET:
  - pll_rst=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK.
  - pll_rst deasserts on the first WAIT_LOCK cycle.
  - Timeout counter clears on WAIT_LOCK entry.
- WAIT_LOCK:
  - locked_s=1 -> STABILIZE, stable counter=0.
  - Timeout counter reaching LOCK_TIMEOUT_CYCLES -> retry.
- STABILIZE:
  - Stable counter increments each cycle with locked_s=1.
  - Reaching LOCK_STABLE_CYCLES -> RELEASE.
  - locked_s=0 -> WAIT_LOCK; stable counter clears, timeout counter keeps running.
  - If timeout and stability complete in the same cycle, timeout wins.
- Retry (timeout in WAIT_LOCK or STABILIZE):
  - If retry_count+1 >= MAX_RETRIES -> FAULT; otherwise -> PLL_RESET.
  - retry_count increments in both cases.
- RELEASE:
  - domain_rst_n[0] goes high on RELEASE entry.
  - Bit k goes high STAGE_GAP_CYCLES after bit k-1.
  - ready goes high one cycle after the last bit releases (state RUN).
  - Released bits never re-assert except on lock loss, soft_rst or reset_n.
- RUN: ready=1, domain_rst_n all 1.
- Lock loss (locked_s=0 in RELEASE or RUN):
  - On the next edge: domain_rst_n=all 0, ready=0, lock_lost=1 for one cycle.
  - State -> PLL_RESET; retry_count increments.
  - Lock loss does not cause FAULT; only timeouts do.
- FAULT:
  - pll_rst=0, domain_rst_n all 0, fault=1.
  - Leaves only via reset_n or soft_rst.
- soft_rst (any state, highest priority over all transitions):
  - Next edge: PLL_RESET, pll_rst=1, domain_rst_n=0, ready=0, fault=0, retry_count=0, counters cleared, lock_lost=0.
- retry_count saturates at 15, never wraps.
- Counters are sized from their parameters with no wrap inside their range.
- reset_n assertion mid-sequence forces the reset values immediately (async), regardless of state.

Test Plan:
Params for all tests: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=40, STAGE_GAP_CYCLES=2, NUM_DOMAINS=3, MAX_RETRIES=2.
1. Nominal: release reset_n; pll_locked=1 from cycle 10 -> pll_rst high exactly 4 cycles; domain_rst_n goes 001, 011, 111 two cycles apart after 8 stable cycles; ready=1 one cycle after 111; retry_count=0.
2. Glitchy lock: drop pll_locked for 1 cycle midway through STABILIZE -> returns to WAIT_LOCK; stable count restarts; release delayed by the glitch; no retry counted.
3. Timeout/fault: pll_locked held 0 -> first timeout gives a retry: retry_count=1, pll_rst pulses 4 cycles. Second timeout -> FAULT: fault=1, retry_count=2, pll_rst=0, domain_rst_n=000.
4. Lock loss in RUN: from RUN, drop pll_locked -> within 3 edges domain_rst_n=000, ready=0, lock_lost pulses 1 cycle, retry_count=1, pll_rst=1 for 4 cycles. Restore lock -> full sequence repeats.
5. soft_rst in FAULT and mid-RELEASE (after domain_rst_n=001) -> next edge: PLL_RESET, fault=0, retry_count=0, domain_rst_n=000, lock_lost=0.
6. Async reset: assert reset_n low in RUN between clock edges -> outputs reach reset values before the next edge; normal sequence resumes after deassert.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Supervises the board PLL from its 25 MHz reference: pulses the PLL reset,
// waits for a lock that stays stable long enough, retries on timeout up to a
// bounded count, then releases the per-domain resets one at a time in index
// order. Every output is a flop, so downstream logic sees no combinational
// glitches. Each downstream domain re-synchronizes its own domain_rst_n bit.

module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,     // cycles pll_rst is held per attempt
  parameter int LOCK_STABLE_CYCLES  = 1024,   // consecutive locked cycles before release
  parameter int LOCK_TIMEOUT_CYCLES = 65536,  // budget from WAIT_LOCK entry to RELEASE
  parameter int STAGE_GAP_CYCLES    = 8,      // spacing between domain releases
  parameter int NUM_DOMAINS         = 3,      // number of domain reset outputs
  parameter int MAX_RETRIES         = 7       // failed attempts tolerated before FAULT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic                   soft_rst,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic                   lock_lost,
  output logic                   fault,
  output logic [3:0]             retry_count
);

  // Each counter is just wide enough to hold its own terminal value, so no
  // counter can wrap while it is inside its range.
  localparam int RST_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(STAGE_GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_PLL_RESET,  // pll_rst held high for PLL_RST_CYCLES
    ST_WAIT_LOCK,  // waiting for synchronized lock
    ST_STABILIZE,  // lock must hold LOCK_STABLE_CYCLES in a row
    ST_RELEASE,    // domain resets released one by one
    ST_RUN,        // all domains out of reset
    ST_FAULT       // retries exhausted; parked until reset_n or soft_rst
  } state_t;

  state_t           state;
  logic [RST_W-1:0] rst_cnt;   // cycles spent in PLL_RESET this attempt
  logic [STB_W-1:0] stb_cnt;   // consecutive locked cycles in STABILIZE
  logic [TMO_W-1:0] tmo_cnt;   // cycles since WAIT_LOCK entry (spans STABILIZE)
  logic [GAP_W-1:0] gap_cnt;   // cycles since the last domain release

  logic             lock_meta; // first synchronizer stage
  logic             locked_s;  // synchronized lock, two cycles behind pll_locked

  logic             rst_done;
  logic             stb_done;
  logic             tmo_done;
  logic             gap_done;
  logic             all_released;
  logic [3:0]       retry_next;
  logic             retry_exhausted;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge value of every other flop, exactly like hardware.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  // Terminal-count detection and the saturating retry increment.
  // NOTE: every signal written here is assigned on every path through the
  // block; a path that skipped one would infer a latch instead of logic.
  always_comb begin
    rst_done        = (rst_cnt + 1'b1) == RST_W'(PLL_RST_CYCLES);
    stb_done        = (stb_cnt + 1'b1) == STB_W'(LOCK_STABLE_CYCLES);
    tmo_done        = (tmo_cnt + 1'b1) == TMO_W'(LOCK_TIMEOUT_CYCLES);
    gap_done        = (gap_cnt + 1'b1) == GAP_W'(STAGE_GAP_CYCLES);
    all_released    = &domain_rst_n;
    retry_next      = (retry_count == 4'd15) ? 4'd15 : retry_count + 4'd1;
    retry_exhausted = ({1'b0, retry_count} + 5'd1) >= 5'(MAX_RETRIES);
  end

  // Sequencer FSM: state, counters and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_PLL_RESET;
      pll_rst      <= 1'b1;
      domain_rst_n <= '0;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      fault        <= 1'b0;
      retry_count  <= 4'd0;
      rst_cnt      <= '0;
      stb_cnt      <= '0;
      tmo_cnt      <= '0;
      gap_cnt      <= '0;
    end else begin
      // lock_lost is a single-cycle pulse; only the lock-loss branch raises it.
      lock_lost <= 1'b0;

      if (soft_rst) begin
        // Restart request beats every other transition, including FAULT.
        state        <= ST_PLL_RESET;
        pll_rst      <= 1'b1;
        domain_rst_n <= '0;
        ready        <= 1'b0;
        fault        <= 1'b0;
        retry_count  <= 4'd0;
        rst_cnt      <= '0;
        stb_cnt      <= '0;
        tmo_cnt      <= '0;
        gap_cnt      <= '0;
      end else begin
        unique case (state)
          ST_PLL_RESET: begin
            if (rst_done) begin
              // The lock budget starts from the first WAIT_LOCK cycle.
              state   <= ST_WAIT_LOCK;
              pll_rst <= 1'b0;
              tmo_cnt <= '0;
              stb_cnt <= '0;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end

          ST_WAIT_LOCK, ST_STABILIZE: begin
            if (tmo_done) begin
              // Timeout is checked first so it wins over a stability
              // completion landing on the same cycle.
              retry_count <= retry_next;
              stb_cnt     <= '0;
              tmo_cnt     <= '0;
              rst_cnt     <= '0;
              if (retry_exhausted) begin
                state <= ST_FAULT;
                fault <= 1'b1;
              end else begin
                state   <= ST_PLL_RESET;
                pll_rst <= 1'b1;
              end
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
              if (state == ST_WAIT_LOCK) begin
                if (locked_s) begin
                  state   <= ST_STABILIZE;
                  stb_cnt <= '0;
                end
              end else if (!locked_s) begin
                // A glitch restarts the stability window but not the budget.
                state   <= ST_WAIT_LOCK;
                stb_cnt <= '0;
              end else if (stb_done) begin
                state        <= ST_RELEASE;
                domain_rst_n <= NUM_DOMAINS'(1);
                gap_cnt      <= '0;
              end else begin
                stb_cnt <= stb_cnt + 1'b1;
              end
            end
          end

          ST_RELEASE, ST_RUN: begin
            if (!locked_s) begin
              // Lock loss after release began: pull every domain back into
              // reset and re-pulse the PLL. Counted, but never a FAULT.
              state        <= ST_PLL_RESET;
              pll_rst      <= 1'b1;
              domain_rst_n <= '0;
              ready        <= 1'b0;
              lock_lost    <= 1'b1;
              retry_count  <= retry_next;
              rst_cnt      <= '0;
              stb_cnt      <= '0;
              tmo_cnt      <= '0;
              gap_cnt      <= '0;
            end else if (state == ST_RELEASE) begin
              if (all_released) begin
                state <= ST_RUN;
                ready <= 1'b1;
              end else if (gap_done) begin
                // Shift in one more released bit, lowest index first.
                domain_rst_n <= (domain_rst_n << 1) | NUM_DOMAINS'(1);
                gap_cnt      <= '0;
              end else begin
                gap_cnt <= gap_cnt + 1'b1;
              end
            end
          end

          ST_FAULT: begin
            // Parked: pll_rst low, domains held, fault high.
            pll_rst      <= 1'b0;
            domain_rst_n <= '0;
            fault        <= 1'b1;
          end

          default: begin
            state   <= ST_PLL_RESET;
            pll_rst <= 1'b1;
            rst_cnt <= '0;
          end
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  // Output relationships that must hold in every reachable state.
  a_ready_all_released : assert property (@(posedge clock) disable iff (!reset_n)
    ready |-> &domain_rst_n);
  a_fault_quiet : assert property (@(posedge clock) disable iff (!reset_n)
    fault |-> (!pll_rst && domain_rst_n == '0 && !ready));
  a_lost_restarts : assert property (@(posedge clock) disable iff (!reset_n)
    lock_lost |-> (pll_rst && domain_rst_n == '0));
`endif

endmodule
